// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the zero-register index.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_lu_cmp.sv
// Combinational load-use detector: a load in ID/EX whose destination feeds either source of IF/ID.
module pipe_hazard_lu_cmp
    import pipe_hazard_pkg::*;
(
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    output logic       o_hazard
);

    logic [4:0] w_src [2];
    logic [1:0] w_match;

    assign w_src[0] = i_ifid_rs;
    assign w_src[1] = i_ifid_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign w_match[gi] = (i_idex_rt == w_src[gi]);
        end
    endgenerate

    // Register zero is hard-wired, so a load targeting it never creates a dependency.
    assign o_hazard = i_idex_mem_read && (i_idex_rt != REG_ZERO) && (|w_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: boot bubbles, load-use stall, branch flush, memory wait and watchdog halt.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned STARTUP_BUBBLES = 2,
    parameter int unsigned MEM_TIMEOUT     = 255
`ifdef HAZARD_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W          = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             err_timeout
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_flushes,
    output logic [PERF_W-1:0] perf_mem_cycles
`endif
);

    localparam logic [3:0]  LP_BOOT_LAST = 4'(STARTUP_BUBBLES - 1);
    localparam logic [15:0] LP_TIMEOUT   = 16'(MEM_TIMEOUT);

    state_t      r_state, w_state_next;
    logic [3:0]  r_boot_cnt, w_boot_cnt_next;
    logic [15:0] r_wait_cnt, w_wait_cnt_next;
    logic        r_err_timeout, w_err_timeout_next;
    logic        w_hazard;
    logic        w_run_eval;

    pipe_hazard_lu_cmp u_lu_cmp (
        .i_idex_mem_read (idex_MemRead),
        .i_idex_rt       (idex_rt),
        .i_ifid_rs       (ifid_rs),
        .i_ifid_rt       (ifid_rt),
        .o_hazard        (w_hazard)
    );

    // RUN rules apply in RUN and in the cycle MEM_WAIT sees memory become ready.
    assign w_run_eval = (r_state == RUN) || ((r_state == MEM_WAIT) && !mem_busy);

    always_comb begin
        w_state_next       = r_state;
        w_boot_cnt_next    = r_boot_cnt;
        w_wait_cnt_next    = r_wait_cnt;
        w_err_timeout_next = r_err_timeout;
        pc_write           = 1'b1;
        ifid_write         = 1'b1;
        ifid_flush         = 1'b0;
        idex_write         = 1'b1;
        idex_bubble        = 1'b0;
        exmem_write        = 1'b1;

        case (r_state)
            BOOT: begin
                idex_bubble     = 1'b1;
                w_boot_cnt_next = r_boot_cnt + 4'd1;
                if (r_boot_cnt == LP_BOOT_LAST) begin
                    w_state_next = RUN;
                end
            end
            HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end
            default: begin
                if (!w_run_eval) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    if (r_wait_cnt == LP_TIMEOUT) begin
                        w_err_timeout_next = 1'b1;
                        w_state_next       = HALT;
                    end else if (r_wait_cnt != 16'hFFFF) begin
                        w_wait_cnt_next = r_wait_cnt + 16'd1;
                    end
                end else begin
                    if (r_state == MEM_WAIT) begin
                        w_state_next    = RUN;
                        w_wait_cnt_next = '0;
                    end
                    if (mem_busy) begin
                        pc_write        = 1'b0;
                        ifid_write      = 1'b0;
                        idex_write      = 1'b0;
                        exmem_write     = 1'b0;
                        w_wait_cnt_next = 16'd1;
                        w_state_next    = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        // Flushing IF/ID and bubbling ID/EX squashes both wrong-path slots at once.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            end
        endcase

        if (reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
            exmem_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BOOT;
            r_boot_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_boot_cnt    <= w_boot_cnt_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    assign err_timeout = r_err_timeout;

`ifdef HAZARD_CTRL_PERF_EN
    logic              w_lu_evt, w_fl_evt, w_mem_evt;
    logic [PERF_W-1:0] r_perf_lu, r_perf_fl, r_perf_mem;

    assign w_lu_evt  = w_run_eval && !mem_busy && !ex_branch_taken && w_hazard;
    assign w_fl_evt  = w_run_eval && !mem_busy && ex_branch_taken;
    assign w_mem_evt = ((r_state == RUN) || (r_state == MEM_WAIT)) && mem_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lu  <= '0;
            r_perf_fl  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (w_lu_evt)  r_perf_lu  <= r_perf_lu + 1'b1;
            if (w_fl_evt)  r_perf_fl  <= r_perf_fl + 1'b1;
            if (w_mem_evt) r_perf_mem <= r_perf_mem + 1'b1;
        end
    end

    assign perf_lu_stalls  = r_perf_lu;
    assign perf_flushes    = r_perf_fl;
    assign perf_mem_cycles = r_perf_mem;
`endif

endmodule
